// File: rtl/sram_responder.sv
// Responder between the single-cycle RAM request interface and an asynchronous SRAM.
// One request is in flight at a time. Strobes that arrive while a request is active are dropped and flagged.
module sram_responder #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              busy_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              overrun_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_data_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);
    localparam int MAXC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_SETUP  = 3'd1;
    localparam logic [2:0] WR_PULSE  = 3'd2;
    localparam logic [2:0] WR_HOLD   = 3'd3;
    localparam logic [2:0] RD_ACCESS = 3'd4;
    localparam logic [2:0] RD_RESP   = 3'd5;

    logic [2:0]        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] wdata_q;
    logic              sram_drv;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE: begin
                if (wr_en_i) begin
                    state_nxt = WR_SETUP;
                end else if (rd_en_i) begin
                    state_nxt = RD_ACCESS;
                    cnt_nxt   = CW'(RD_CYCLES - 1);
                end
            end
            WR_SETUP: begin
                state_nxt = WR_PULSE;
                cnt_nxt   = CW'(WR_CYCLES - 1);
            end
            WR_PULSE: begin
                if (cnt == '0) state_nxt = WR_HOLD;
                else           cnt_nxt   = cnt - CW'(1);
            end
            WR_HOLD:   state_nxt = IDLE;
            RD_ACCESS: begin
                if (cnt == '0) state_nxt = RD_RESP;
                else           cnt_nxt   = cnt - CW'(1);
            end
            RD_RESP:   state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Pin controls are registered from the next-state decode so they change cleanly on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
            sram_drv    <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            sram_addr_o <= '0;
            wdata_q     <= '0;
            overrun_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sram_ce_n_o <= !(state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD, RD_ACCESS});
            sram_we_n_o <= (state_nxt != WR_PULSE);
            sram_oe_n_o <= (state_nxt != RD_ACCESS);
            sram_drv    <= (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD});
            rd_valid_o  <= (state_nxt == RD_RESP);
            if (state == IDLE && (wr_en_i || rd_en_i)) sram_addr_o <= addr_i;
            if (state == IDLE && wr_en_i)              wdata_q     <= data_io;
            if (state == RD_ACCESS && cnt == '0)       rd_data_o   <= sram_data_io;
            if ((state != IDLE && (wr_en_i || rd_en_i)) || (state == IDLE && wr_en_i && rd_en_i))
                overrun_o <= 1'b1;
        end
    end

    assign busy_o       = (state != IDLE);
    assign sram_data_io = sram_drv   ? wdata_q   : {DATA_W{1'bz}};
    assign data_io      = rd_valid_o ? rd_data_o : {DATA_W{1'bz}};

endmodule
